fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that feeds the decode-stage control unit (opcode/funct) and register file. Resolves PC redirection for taken branches and jumps decided in ID, inserts bubbles on redirect or external flush, honours hazard-unit stalls, and keeps fetch/bubble performance counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall_f  in  1  hazard unit: hold PC
- stall_d  in  1  hazard unit: hold IF/ID register
- flush_d  in  1  hazard unit: load bubble into IF/ID
- pc_src_d  in  1  branch taken, from ID (branch & equal)
- jump_d  in  1  jump, from ID control unit
- imem_addr  out  32  instruction-memory address (= PC)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- instr_d  out  32  IF/ID instruction
- pc_plus4_d  out  32  IF/ID PC+4
- opcode_d  out  6  instr_d[31:26]
- funct_d  out  6  instr_d[5:0]
- valid_d  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_count  out  32  valid instructions loaded into IF/ID
- bubble_count  out  32  bubbles inserted into IF/ID

## Operation
- PC register pc_f; imem_addr = pc_f continuously.
- Targets (combinational, from IF/ID contents): branch_tgt = pc_plus4_d + (sign-extend instr_d[15:0] << 2), 32-bit wrap; jump_tgt = {pc_plus4_d[31:28], instr_d[25:0], 2'b00}.
- redirect = (pc_src_d | jump_d) & ~stall_d & valid_d. Redirect requests while stalled or with a bubble in ID are ignored.
- PC next-state priority: reset -> RESET_PC; redirect & jump_d -> jump_tgt (jump wins over branch); redirect -> branch_tgt; stall_f -> hold; else pc_f + 4 (wraps at 2^32).
- IF/ID next-state priority: reset -> bubble; flush_d | redirect -> bubble; stall_d -> hold; else {instr_d, pc_plus4_d, valid_d} <= {imem_rdata, pc_f + 4, 1}.
- Bubble = instr_d 32'h0000_0000 (sll $0,$0,0 nop), pc_plus4_d 0, valid_d 0; opcode/funct read 0, decoding as harmless R-type.
- flush_d with stall_d: flush wins.
- fetch_count += 1 on each edge loading a valid instruction; bubble_count += 1 on each edge loading a bubble by flush/redirect (not reset, not while holding). Both wrap mod 2^32.

## Timing
- Reset (rst_n sampled low at edge): pc_f = RESET_PC, instr_d = 0, pc_plus4_d = 0, valid_d = 0, counters = 0. Reset mid-operation discards all in-flight state the same edge.
- First edge after rst_n high: IF/ID loads mem[RESET_PC], pc_f = RESET_PC + 4.
- Fetch-to-decode latency: 1 cycle. imem read is same-cycle combinational.
- Redirect penalty: 1 bubble. Cycle N: branch/jump in ID, redirect=1; edge N: pc_f <= target, IF/ID <= bubble; edge N+1: IF/ID <= mem[target].
- Stall: each cycle stall_f & stall_d high holds PC and IF/ID unchanged, counters unchanged.
- No combinational path from any input to any output except imem_rdata -> none (registered) and IF/ID -> targets (internal only).

## Structure
- Shared package mips_pkg: NOP_INSTR (32'h0), instruction field positions (opcode 31:26, funct 5:0, imm 15:0, jaddr 25:0), default RESET_PC, word width.
- One sub-module: pipe_reg_en_clr, parameterized-width register with synchronous active-low reset, enable (~stall) and clear (bubble); instantiated for IF/ID. PC, target logic and counters inline.

## Test plan
- Reset then 4 free-running cycles, imem[0..3]=0x20080005,0x20090003,0x01095020,0xAC0A0000 -> instr_d shows each in order one cycle late, pc_plus4_d 4,8,12,16, fetch_count=4, valid_d=1.
- beq at PC 0x10, imm 0x0003, pc_src_d=1 -> next pc_f=0x20, one bubble (valid_d=0, instr_d=0), bubble_count=1, then instr_d=mem[0x20].
- j with target field 0x0000040 at PC 0x08 -> pc_f=0x100; simultaneous pc_src_d=1 -> jump still wins, pc_f=0x100.
- stall_f=stall_d=1 for 3 cycles at pc_f=0x14 -> pc_f, instr_d, counters frozen; pc_src_d=1 during stall ignored; release resumes at 0x18.
- flush_d=1 with stall_d=1 -> bubble loaded, bubble_count+1; branch imm 0xFFFF at pc_plus4_d=0x0 -> branch_tgt wraps to 0xFFFFFFFC.
- rst_n low for one edge mid-stream at pc_f=0x40 -> pc_f=RESET_PC, valid_d=0, both counters 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   - word width, default reset PC, canonical NOP encoding
//   - instruction field bit positions (opcode, funct, imm, jump address)
//   - ifid_t: packed layout of the IF/ID pipeline register
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // sll $0,$0,0 -- decodes as a harmless R-type, so a bubble is all zeros.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int JADDR_HI  = 25;
    localparam int JADDR_LO  = 0;

    // IF/ID contents. A bubble is the all-zero value of this struct.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

endpackage : mips_pkg

// File: rtl/pipe_reg_en_clr.sv
// ----------------------------------------------------------------------------
// pipe_reg_en_clr
// Generic pipeline register with synchronous active-low reset, synchronous
// clear and load enable. Priority: reset, clear, enable, hold.
// Both reset and clear load all zeros.
// Ports:
//   clk      in  1  clock
//   rst_n    in  1  synchronous active-low reset
//   i_en     in  1  load i_d when high (and not clearing)
//   i_clr    in  1  load zeros (overrides i_en)
//   i_d      in  W  next value
//   o_q      out W  registered value
// ----------------------------------------------------------------------------
module pipe_reg_en_clr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_reg_en_clr

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives
// the instruction-memory address, registers the fetched word into IF/ID,
// redirects the PC for branches/jumps resolved in ID, inserts bubbles on
// redirect or flush, honours hazard-unit stalls and counts fetches/bubbles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   stall_f, stall_d      hold PC / hold IF/ID
//   flush_d               load bubble into IF/ID
//   pc_src_d, jump_d      branch taken / jump, decided in ID
//   imem_addr             instruction-memory address (= PC)
//   imem_rdata            combinational instruction word at imem_addr
//   instr_d, pc_plus4_d   IF/ID contents
//   opcode_d, funct_d     fields of instr_d for the decode control unit
//   valid_d               IF/ID holds a real instruction (0 = bubble)
//   fetch_count           valid instructions loaded into IF/ID
//   bubble_count          bubbles loaded into IF/ID by flush/redirect
// RESET_PC must be word-aligned.
// ----------------------------------------------------------------------------
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_d,
    input  logic        jump_d,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic [5:0]  opcode_d,
    output logic [5:0]  funct_d,
    output logic        valid_d,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    logic [31:0] r_pc_f;
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    ifid_t       w_ifid_d;
    ifid_t       w_ifid_q;
    logic [31:0] w_pc_plus4_f;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_pc_next;
    logic [15:0] w_imm;
    logic        w_redirect;
    logic        w_bubble;
    logic        w_load;

    assign w_pc_plus4_f = r_pc_f + 32'd4;

    // Targets come from the instruction sitting in ID, not from the fetch.
    assign w_imm        = w_ifid_q.instr[IMM_HI:IMM_LO];
    assign w_branch_tgt = w_ifid_q.pc_plus4 + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign w_jump_tgt   = {w_ifid_q.pc_plus4[31:28],
                           w_ifid_q.instr[JADDR_HI:JADDR_LO], 2'b00};

    // A branch/jump stuck behind a stall, or a bubble in ID, must not steer
    // the PC; it is re-evaluated once ID actually advances.
    assign w_redirect = (pc_src_d | jump_d) & ~stall_d & w_ifid_q.valid;
    assign w_bubble   = flush_d | w_redirect;
    assign w_load     = ~stall_d & ~w_bubble;

    always_comb begin
        w_pc_next = w_pc_plus4_f;
        if (w_redirect && jump_d) begin
            w_pc_next = w_jump_tgt;
        end else if (w_redirect) begin
            w_pc_next = w_branch_tgt;
        end else if (stall_f) begin
            w_pc_next = r_pc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_f <= RESET_PC;
        end else begin
            r_pc_f <= w_pc_next;
        end
    end

    assign w_ifid_d.instr    = imem_rdata;
    assign w_ifid_d.pc_plus4 = w_pc_plus4_f;
    assign w_ifid_d.valid    = 1'b1;

    // Clear (bubble) outranks enable, so a flush wins over a stall.
    pipe_reg_en_clr #(
        .W ($bits(ifid_t))
    ) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (~stall_d),
        .i_clr (w_bubble),
        .i_d   (w_ifid_d),
        .o_q   (w_ifid_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count  <= '0;
            r_bubble_count <= '0;
        end else begin
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_bubble) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end
        end
    end

    assign imem_addr    = r_pc_f;
    assign instr_d      = w_ifid_q.instr;
    assign pc_plus4_d   = w_ifid_q.pc_plus4;
    assign valid_d      = w_ifid_q.valid;
    assign opcode_d     = w_ifid_q.instr[OPCODE_HI:OPCODE_LO];
    assign funct_d      = w_ifid_q.instr[FUNCT_HI:FUNCT_LO];
    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;

endmodule : fetch_stage
